mmio_store_sink: RTL and testbench
==================================

# mmio_store_sink

Memory-mapped store responder on the core's exported data-memory write port (store-data, byte address, write enable from the MEM stage). It decodes word stores to a small MMIO window and acts on them: a tohost register that ends simulation with pass/fail, a UART transmit path (FIFO plus 8N1 serializer), and a GPIO output register. Stores outside the window are ignored; data memory handles them as before.

## Interface
- XLEN, riscv_pkg::XLEN, data/address width (32 only)
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be ≥2
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- MemWriteM  input  1  store strobe, one cycle per store
- ALUResultM  input  XLEN  store byte address
- WriteDataM  input  XLEN  store data
- UartTx  output  1  serial line, idle high
- TxBusy  output  1  FIFO non-empty or serializer not IDLE
- TxOverflow  output  1  sticky: a byte was dropped on a full FIFO
- Done  output  1  sticky: tohost written
- Pass  output  1  valid when Done; tohost value == 1
- ExitCode  output  XLEN-1  tohost value [XLEN-1:1]
- GpioOut  output  XLEN  GPIO register

## Operation
- Decode: exact XLEN-bit address compare while MemWriteM=1. MMIO_TOHOST_ADDR=0xFFFF_FF00, MMIO_UART_TX_ADDR=0xFFFF_FF04, MMIO_GPIO_ADDR=0xFFFF_FF08. Any other address, including misaligned neighbours, is ignored.
- tohost: the first store sets Done=1, Pass=(data==1), ExitCode=data[XLEN-1:1]. Later tohost stores are ignored until rst.
- GPIO: every store overwrites GpioOut, last write wins.
- UART store: pushes WriteDataM[7:0] into the FIFO; bits [XLEN-1:8] are ignored.
  - Full FIFO with no pop that cycle: byte is dropped and TxOverflow set (sticky).
  - Full FIFO with a pop in the same cycle: push is accepted.
- Serializer FSM states IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into a shift register and go to START.
  - START: UartTx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: UartTx=1 for CLKS_PER_BIT cycles, then IDLE.
  - In IDLE, UartTx=1.
- Counters: baud counter counts 0..CLKS_PER_BIT-1; bit index counts 0..7. FIFO pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally; full/empty are decided from the MSB.

## Timing
- Reset values:
  - UartTx=1, TxBusy=0, TxOverflow=0, Done=0, Pass=0, ExitCode=0, GpioOut=0.
  - FIFO empty, FSM IDLE.
- Reset mid-frame aborts the frame; UartTx=1 from the next cycle.
- Register updates (tohost, GPIO, FIFO push): store sampled at edge k; outputs change after edge k (1-cycle latency).
- UART latency: byte pushed at edge k into an empty FIFO with FSM IDLE → popped at edge k+1 → UartTx=0 from edge k+1.
- Frame length: 10×CLKS_PER_BIT cycles.
- Back-to-back frames: exactly one IDLE cycle (UartTx=1) between STOP end and the next START.
- TxBusy goes high after the push edge and low after the last STOP cycle when the FIFO is empty.
- Simultaneous tohost and other events cannot occur (one store per cycle). Rst has priority over any store in the same cycle.

## Structure
- riscv_pkg gains:
  - MMIO_TOHOST_ADDR, MMIO_UART_TX_ADDR, MMIO_GPIO_ADDR constants.
  - typedef enum logic [1:0] uart_tx_state_e {UTX_IDLE, UTX_START, UTX_DATA, UTX_STOP}.
- Sub-module uart_tx: FSM, baud counter, shift register. Interface: valid/ready byte input, UartTx, busy.
- FIFO and address decode stay inline in mmio_store_sink.
- Top-level testbench instantiates the block on top's three exported signals.

## Test plan
Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4.

- Store 0x0000_0001 to 0xFFFF_FF00 → Done=1, Pass=1, ExitCode=0 the next cycle. A second store of 0x7 is ignored.
- Store 0x0000_0007 to tohost after reset → Pass=0, ExitCode=3.
- Store 0x1234_5641 ('A') to 0xFFFF_FF04:
  - UartTx reads 0 (start), then 1,0,0,0,0,0,1,0, then 1 (stop), each held 4 cycles.
  - Frame is 40 cycles; TxBusy deasserts after it.
- Six consecutive UART stores of 0x30..0x35 →
  - 0x30 is popped on the first push's next edge; 0x31..0x34 fill the FIFO; 0x35 is dropped and TxOverflow=1.
  - Line carries 0x30..0x34 with a 1-cycle gap between frames.
- Store 0xDEAD_BEEF to 0xFFFF_FF08 → GpioOut=0xDEADBEEF. A store to 0xFFFF_FF09 or 0x0000_0100 leaves GpioOut and the FIFO unchanged.
- Assert rst for 1 cycle mid-DATA → UartTx=1, TxBusy=0, FIFO empty, all flags 0 on the following cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants: data width, MMIO window addresses and UART serializer states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] MMIO_TOHOST_ADDR  = 32'hFFFF_FF00;
  localparam logic [31:0] MMIO_UART_TX_ADDR = 32'hFFFF_FF04;
  localparam logic [31:0] MMIO_GPIO_ADDR    = 32'hFFFF_FF08;

  typedef enum logic [1:0] {
    UTX_IDLE,
    UTX_START,
    UTX_DATA,
    UTX_STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: accepts one byte per frame via valid/ready, drives the line LSB first.
module uart_tx
  import riscv_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  uart_tx_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    in_ready_o = 1'b0;
    tx_o       = 1'b1;
    unique case (state_q)
      UTX_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          shift_d = in_data_i;
          cnt_d   = '0;
          state_d = UTX_START;
        end
      end
      UTX_START: begin
        tx_o = 1'b0;
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = UTX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UTX_DATA: begin
        tx_o = shift_q[0];
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UTX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UTX_STOP: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = UTX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = UTX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UTX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign busy_o = (state_q != UTX_IDLE);

endmodule

// File: rtl/mmio_store_sink.sv
// MMIO store responder: decodes word stores to tohost, UART TX FIFO and GPIO registers.
module mmio_store_sink
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = riscv_pkg::XLEN,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic            UartTx,
  output logic            TxBusy,
  output logic            TxOverflow,
  output logic            Done,
  output logic            Pass,
  output logic [XLEN-2:0] ExitCode,
  output logic [XLEN-1:0] GpioOut
);

  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic hit_tohost, hit_uart, hit_gpio;
  assign hit_tohost = MemWriteM && (ALUResultM == MMIO_TOHOST_ADDR);
  assign hit_uart   = MemWriteM && (ALUResultM == MMIO_UART_TX_ADDR);
  assign hit_gpio   = MemWriteM && (ALUResultM == MMIO_GPIO_ADDR);

  logic            done_q, done_d, pass_q, pass_d, ovf_q, ovf_d;
  logic [XLEN-2:0] exit_q, exit_d;
  logic [XLEN-1:0] gpio_q, gpio_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop, tx_ready, tx_busy;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                      (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign pop        = !fifo_empty && tx_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push       = hit_uart && (!fifo_full || pop);

  always_comb begin
    done_d   = done_q;
    pass_d   = pass_q;
    exit_d   = exit_q;
    gpio_d   = gpio_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (hit_tohost && !done_q) begin
      done_d = 1'b1;
      pass_d = (WriteDataM == XLEN'(1));
      exit_d = WriteDataM[XLEN-1:1];
    end
    if (hit_gpio) begin
      gpio_d = WriteDataM;
    end
    if (hit_uart && !push) begin
      ovf_d = 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      exit_q   <= '0;
      gpio_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      done_q   <= done_d;
      pass_q   <= pass_d;
      exit_q   <= exit_d;
      gpio_q   <= gpio_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[IdxW-1:0]] <= WriteDataM[7:0];
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (!fifo_empty),
    .in_data_i  (fifo_q[rd_ptr_q[IdxW-1:0]]),
    .in_ready_o (tx_ready),
    .tx_o       (UartTx),
    .busy_o     (tx_busy)
  );

  assign TxBusy     = !fifo_empty || tx_busy;
  assign TxOverflow = ovf_q;
  assign Done       = done_q;
  assign Pass       = pass_q;
  assign ExitCode   = exit_q;
  assign GpioOut    = gpio_q;

endmodule

// File: tb/tb_mmio_store_sink.sv
// Directed bench for mmio_store_sink: tohost, UART framing/FIFO overflow, GPIO decode, reset.
module tb_mmio_store_sink;
  import riscv_pkg::*;

  localparam int unsigned Cpb = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        UartTx, TxBusy, TxOverflow, Done, Pass;
  logic [30:0] ExitCode;
  logic [31:0] GpioOut;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmio_store_sink #(
    .XLEN         (32),
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .UartTx     (UartTx),
    .TxBusy     (TxBusy),
    .TxOverflow (TxOverflow),
    .Done       (Done),
    .Pass       (Pass),
    .ExitCode   (ExitCode),
    .GpioOut    (GpioOut)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemWriteM  = 1'b1;
    ALUResultM = addr;
    WriteDataM = data;
    @(negedge clk);
    MemWriteM  = 1'b0;
  endtask

  // Returns at the last STOP cycle; gap counts idle-high samples before the start bit.
  task automatic rx_frame(output logic [7:0] b, output logic stop, output int gap,
                          output logic tmo);
    gap = 0;
    tmo = 1'b0;
    b = '0;
    stop = 1'b0;
    forever begin
      @(negedge clk);
      if (UartTx == 1'b0) break;
      gap++;
      if (gap > 500) begin
        tmo = 1'b1;
        return;
      end
    end
    for (int i = 0; i < 8; i++) begin
      repeat (Cpb) @(negedge clk);
      b[i] = UartTx;
    end
    repeat (Cpb) @(negedge clk);
    stop = UartTx;
    repeat (Cpb - 1) @(negedge clk);
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] exp_byte;

    // Reset state
    do_reset();
    check_eq("rst_uarttx", UartTx, 1);
    check_eq("rst_txbusy", TxBusy, 0);
    check_eq("rst_ovf", TxOverflow, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_pass", Pass, 0);
    check_eq("rst_exit", ExitCode, 0);
    check_eq("rst_gpio", GpioOut, 0);

    // tohost pass, then a second store is ignored
    store(MMIO_TOHOST_ADDR, 32'h0000_0001);
    check_eq("th1_done", Done, 1);
    check_eq("th1_pass", Pass, 1);
    check_eq("th1_exit", ExitCode, 0);
    store(MMIO_TOHOST_ADDR, 32'h0000_0007);
    check_eq("th2_done", Done, 1);
    check_eq("th2_pass", Pass, 1);
    check_eq("th2_exit", ExitCode, 0);

    // tohost fail code
    do_reset();
    store(MMIO_TOHOST_ADDR, 32'h0000_0007);
    check_eq("th7_done", Done, 1);
    check_eq("th7_pass", Pass, 0);
    check_eq("th7_exit", ExitCode, 3);

    // Single frame 'A', upper data bits ignored
    do_reset();
    store(MMIO_UART_TX_ADDR, 32'h1234_5641);
    check_eq("a_pre_tx", UartTx, 1);
    check_eq("a_pre_busy", TxBusy, 1);
    frame = 10'b1_0100_0001_0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_eq($sformatf("a_bit%0d", i), UartTx, frame[i / Cpb]);
    end
    check_eq("a_busy_in", TxBusy, 1);
    @(negedge clk);
    check_eq("a_busy_end", TxBusy, 0);
    check_eq("a_idle_tx", UartTx, 1);

    // Burst of six: 0x30 popped at once, 0x31..0x34 fill the FIFO, 0x35 dropped
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 5) check_eq("ovf_before", TxOverflow, 0);
          MemWriteM  = 1'b1;
          ALUResultM = MMIO_UART_TX_ADDR;
          WriteDataM = 32'h30 + 32'(i);
        end
        @(negedge clk);
        MemWriteM = 1'b0;
        check_eq("ovf_set", TxOverflow, 1);
      end
      begin
        logic [7:0] b;
        logic       stop, tmo;
        int         gap;
        for (int f = 0; f < 5; f++) begin
          rx_frame(b, stop, gap, tmo);
          check_eq($sformatf("burst_tmo%0d", f), tmo, 0);
          if (tmo) break;
          exp_byte = 8'h30 + 8'(f);
          check_eq($sformatf("burst_byte%0d", f), b, exp_byte);
          check_eq($sformatf("burst_stop%0d", f), stop, 1);
          if (f > 0) check_eq($sformatf("burst_gap%0d", f), gap, 1);
        end
      end
    join
    @(negedge clk);
    check_eq("burst_busy_end", TxBusy, 0);
    check_eq("burst_ovf_sticky", TxOverflow, 1);

    // GPIO and ignored neighbours
    do_reset();
    store(MMIO_GPIO_ADDR, 32'hDEAD_BEEF);
    check_eq("gpio_set", GpioOut, 32'hDEAD_BEEF);
    store(32'hFFFF_FF09, 32'h1111_1111);
    check_eq("gpio_ff09", GpioOut, 32'hDEAD_BEEF);
    check_eq("ff09_busy", TxBusy, 0);
    store(32'h0000_0100, 32'h2222_2222);
    check_eq("gpio_0100", GpioOut, 32'hDEAD_BEEF);
    check_eq("x0100_busy", TxBusy, 0);
    store(32'hFFFF_FF05, 32'h0000_0055);
    check_eq("ff05_busy", TxBusy, 0);
    check_eq("ff05_tx", UartTx, 1);
    store(32'hFFFF_FF01, 32'h0000_0001);
    check_eq("ff01_done", Done, 0);

    // Reset mid-DATA aborts frame and clears everything
    do_reset();
    store(MMIO_TOHOST_ADDR, 32'h0000_0001);
    store(MMIO_GPIO_ADDR, 32'h0000_0005);
    store(MMIO_UART_TX_ADDR, 32'h0000_0000);
    store(MMIO_UART_TX_ADDR, 32'h0000_0000);
    repeat (6) @(negedge clk);
    check_eq("mid_tx_low", UartTx, 0);
    check_eq("mid_busy", TxBusy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("ar_tx", UartTx, 1);
    check_eq("ar_busy", TxBusy, 0);
    check_eq("ar_ovf", TxOverflow, 0);
    check_eq("ar_done", Done, 0);
    check_eq("ar_pass", Pass, 0);
    check_eq("ar_gpio", GpioOut, 0);
    repeat (3) @(negedge clk);
    check_eq("ar_tx_hold", UartTx, 1);
    check_eq("ar_busy_hold", TxBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
